wb_stage: RTL

//  Writeback stage of the 5-stage RV32I pipeline, and the write-side driver of the register file.
//  - Captures retiring instructions from MEM.
//  - Waits for the data-memory load response, then aligns and sign-/zero-extends the load data.
//  - Drives the register-file write port (rf_we/rf_waddr/rf_wdata) and mirrors it as a forwarding source.
//  - Stalls upstream while a load is outstanding.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/load_extend.sv | 47 ++++
 rtl/wb_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: result source select, load funct3 encodings, writeback FSM states.
package riscv_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment: picks the byte/halfword lane from a word-aligned read and extends it.
// Also flags halfword/word accesses that are not naturally aligned.
module load_extend
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data,
   output logic            misaligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (addr)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data       = rdata;
      misaligned = 1'b0;
      case (funct3)
         LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
         LBU: data = {{(XLEN-8){1'b0}}, byte_v};
         LH: begin
            data       = {{(XLEN-16){half_v[15]}}, half_v};
            misaligned = addr[0];
         end
         LHU: begin
            data       = {{(XLEN-16){1'b0}}, half_v};
            misaligned = addr[0];
         end
         LW:      misaligned = |addr;
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, waits for load data, drives the register-file write port.
// Non-loads write one cycle after accept; loads write one cycle after dmem_rvalid, stalling upstream meanwhile.
module wb_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_reg_write,
   input  logic [4:0]       in_rd,
   input  logic [1:0]       in_res_src,
   input  logic [XLEN-1:0]  in_alu,
   input  logic [XLEN-1:0]  in_pc4,
   input  logic [2:0]       in_funct3,
   input  logic             dmem_rvalid,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             stall_o,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic             misalign_err,
   output logic [CNT_W-1:0] retired_cnt
);

   wb_state_e        state_q, state_d;
   logic [4:0]       rd_q, rd_d;
   logic             wen_q, wen_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       addr_q, addr_d;
   logic             rf_we_q, rf_we_d;
   logic [4:0]       rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
   logic             mis_q, mis_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]  ld_data;
   logic             ld_mis;

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .funct3     (f3_q),
      .addr       (addr_q),
      .rdata      (dmem_rdata),
      .data       (ld_data),
      .misaligned (ld_mis)
   );

   assign in_ready = (state_q == IDLE);
   assign stall_o  = in_valid & ~in_ready;

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      wen_d      = wen_q;
      f3_d       = f3_q;
      addr_d     = addr_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      mis_d      = 1'b0;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (in_res_src == RES_LOAD) begin
                  state_d = WAIT;
                  rd_d    = in_rd;
                  wen_d   = in_reg_write && (in_rd != 5'd0);
                  f3_d    = in_funct3;
                  addr_d  = in_alu[1:0];
               end else begin
                  rf_we_d = in_reg_write && (in_rd != 5'd0);
                  if (rf_we_d) begin
                     rf_waddr_d = in_rd;
                     rf_wdata_d = (in_res_src == RES_PC4) ? in_pc4 : in_alu;
                  end
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               state_d = IDLE;
               cnt_d   = cnt_q + CNT_W'(1);
               // A misaligned load still retires but never reaches the register file.
               if (ld_mis) begin
                  mis_d = 1'b1;
               end else if (wen_q) begin
                  rf_we_d    = 1'b1;
                  rf_waddr_d = rd_q;
                  rf_wdata_d = ld_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rd_q       <= '0;
         wen_q      <= 1'b0;
         f3_q       <= '0;
         addr_q     <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         mis_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         wen_q      <= wen_d;
         f3_q       <= f3_d;
         addr_q     <= addr_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         mis_q      <= mis_d;
         cnt_q      <= cnt_d;
      end
   end

   assign rf_we        = rf_we_q;
   assign rf_waddr     = rf_waddr_q;
   assign rf_wdata     = rf_wdata_q;
   assign fwd_valid    = rf_we_q;
   assign fwd_rd       = rf_waddr_q;
   assign fwd_data     = rf_wdata_q;
   assign misalign_err = mis_q;
   assign retired_cnt  = cnt_q;

endmodule
